// File: rtl/types_pkg.sv
// Shared types for the data-memory port arbiter: FSM encoding, queued
// store and latched load descriptors, and load width codes.
package types_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ST_ISSUE = 2'd1,
    LD_ISSUE = 2'd2,
    LD_WAIT  = 2'd3
  } mem_arb_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        sh;
  } st_req_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  func3;
    logic [6:0]  pd;
    logic [4:0]  rob_tag;
  } ld_req_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/st_fifo.sv
// Retired-store buffer. Pushes while full and pops while empty are ignored;
// pointers wrap naturally because DEPTH is a power of two.
module st_fifo
  import types_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  st_req_t       push_data,
  input  logic          pop,
  output st_req_t       head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  st_req_t       mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_s;
  logic          pop_s;

  assign full   = (count_r == CW'(DEPTH));
  assign empty  = (count_r == '0);
  assign count  = count_r;
  assign head   = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Storage, pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Single data-memory port shared between retired stores (buffered) and
// loads from the mem FU. Stores win by default; a waiting load wins after
// STARVE_MAX consecutive store grants. Memory-side outputs are registered.
module mem_port_arb
  import types_pkg::*;
#(
  parameter int SQ_DEPTH   = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        store_wb,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic        st_sh,
  output logic        sq_full,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_func3,
  input  logic [6:0]  ld_pd,
  input  logic [4:0]  ld_rob_tag,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [6:0]  wb_pd,
  output logic [4:0]  wb_rob_tag,
  output logic [31:0] wb_data
);

  localparam int CW = $clog2(SQ_DEPTH + 1);
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STREAK_SAT = SW'(STARVE_MAX);

  mem_arb_state_t state_r, next_state_s;
  logic [SW-1:0]  streak_r;
  ld_req_t        ld_r, ld_next_s;
  st_req_t        st_push_s, head_s;
  logic [CW-1:0]  sq_count_s;
  logic           full_s, empty_s, pop_s, ld_go_s, sq_ovf_r;
  logic [3:0]     st_be_s;
  logic [31:0]    st_wdata_s;

  // Pick the byte/half selected by the address offset and extend per func3.
  function automatic logic [31:0] ld_extend(input logic [2:0] func3,
                                            input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (func3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  assign st_push_s = '{addr: st_addr, data: st_data, sh: st_sh};
  assign sq_full   = full_s;
  assign ld_ready  = ld_go_s;

  st_fifo #(.DEPTH(SQ_DEPTH)) u_st_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (store_wb),
    .push_data (st_push_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (sq_count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  // Arbitration and transaction sequencing.
  always_comb begin
    next_state_s = state_r;
    ld_go_s      = 1'b0;
    pop_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          if (ld_valid && (streak_r == STREAK_SAT)) begin
            next_state_s = LD_ISSUE;
            ld_go_s      = 1'b1;
          end else begin
            next_state_s = ST_ISSUE;
          end
        end else if (ld_valid) begin
          next_state_s = LD_ISSUE;
          ld_go_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          next_state_s = IDLE;
          pop_s        = 1'b1;
        end else begin
          next_state_s = ST_ISSUE;
        end
      end
      LD_ISSUE: begin
        if (mem_ready) begin
          next_state_s = LD_WAIT;
        end else begin
          next_state_s = LD_ISSUE;
        end
      end
      LD_WAIT: begin
        if (mem_rvalid) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = LD_WAIT;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Load descriptor to hold: fresh fields on the granting cycle, else the latch.
  always_comb begin
    if (ld_go_s) begin
      ld_next_s = '{addr: ld_addr, func3: ld_func3, pd: ld_pd, rob_tag: ld_rob_tag};
    end else begin
      ld_next_s = ld_r;
    end
  end

  // Byte enables and lane-replicated data for the store at the FIFO head.
  always_comb begin
    if (head_s.sh) begin
      st_be_s    = 4'b0011 << {head_s.addr[1], 1'b0};
      st_wdata_s = {2{head_s.data[15:0]}};
    end else begin
      st_be_s    = 4'b1111;
      st_wdata_s = head_s.data;
    end
  end

  // FSM state, latched load, store streak and sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      ld_r     <= '0;
      streak_r <= '0;
      sq_ovf_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ld_r    <= ld_next_s;
      if (ld_go_s) begin
        streak_r <= '0;
      end else if (pop_s && (streak_r != STREAK_SAT)) begin
        streak_r <= streak_r + 1'b1;
      end else begin
        streak_r <= streak_r;
      end
      if (store_wb && full_s) begin
        sq_ovf_r <= 1'b1;
      end else begin
        sq_ovf_r <= sq_ovf_r;
      end
    end
  end

  // Memory request outputs, registered from the state being entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
    end else begin
      case (next_state_s)
        ST_ISSUE: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= {head_s.addr[31:2], 2'b00};
          mem_wdata <= st_wdata_s;
          mem_be    <= st_be_s;
        end
        LD_ISSUE: begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b0;
          mem_addr  <= {ld_next_s.addr[31:2], 2'b00};
          mem_wdata <= 32'd0;
          mem_be    <= 4'd0;
        end
        default: begin
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          mem_addr  <= 32'd0;
          mem_wdata <= 32'd0;
          mem_be    <= 4'd0;
        end
      endcase
    end
  end

  // One-cycle load writeback; read returns outside LD_WAIT are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid   <= 1'b0;
      wb_pd      <= 7'd0;
      wb_rob_tag <= 5'd0;
      wb_data    <= 32'd0;
    end else if ((state_r == LD_WAIT) && mem_rvalid) begin
      wb_valid   <= 1'b1;
      wb_pd      <= ld_r.pd;
      wb_rob_tag <= ld_r.rob_tag;
      wb_data    <= ld_extend(ld_r.func3, ld_r.addr[1:0], mem_rdata);
    end else begin
      wb_valid   <= 1'b0;
      wb_pd      <= wb_pd;
      wb_rob_tag <= wb_rob_tag;
      wb_data    <= wb_data;
    end
  end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed bench for mem_port_arb: a default instance (SQ_DEPTH=2) and a
// SQ_DEPTH=4 instance share all inputs; each step checks one of them.
module tb_mem_port_arb;
  import types_pkg::*;

  logic        clk, reset;
  logic        store_wb, st_sh, ld_valid, mem_ready, mem_rvalid;
  logic [31:0] st_addr, st_data, ld_addr, mem_rdata;
  logic [2:0]  ld_func3;
  logic [6:0]  ld_pd;
  logic [4:0]  ld_rob_tag;

  logic        sq_full2, ld_ready2, mem_req2, mem_we2, wb_valid2;
  logic [31:0] mem_addr2, mem_wdata2, wb_data2;
  logic [3:0]  mem_be2;
  logic [6:0]  wb_pd2;
  logic [4:0]  wb_rob_tag2;

  logic        sq_full4, ld_ready4, mem_req4, mem_we4, wb_valid4;
  logic [31:0] mem_addr4, mem_wdata4, wb_data4;
  logic [3:0]  mem_be4;
  logic [6:0]  wb_pd4;
  logic [4:0]  wb_rob_tag4;

  int checks = 0;
  int errors = 0;
  logic [31:0] grants [4];
  int ngrant;

  mem_port_arb dut2 (
    .clk(clk), .reset(reset), .store_wb(store_wb), .st_addr(st_addr), .st_data(st_data),
    .st_sh(st_sh), .sq_full(sq_full2), .ld_valid(ld_valid), .ld_ready(ld_ready2),
    .ld_addr(ld_addr), .ld_func3(ld_func3), .ld_pd(ld_pd), .ld_rob_tag(ld_rob_tag),
    .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
    .mem_be(mem_be2), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid2), .wb_pd(wb_pd2), .wb_rob_tag(wb_rob_tag2), .wb_data(wb_data2)
  );

  mem_port_arb #(.SQ_DEPTH(4), .STARVE_MAX(2)) dut4 (
    .clk(clk), .reset(reset), .store_wb(store_wb), .st_addr(st_addr), .st_data(st_data),
    .st_sh(st_sh), .sq_full(sq_full4), .ld_valid(ld_valid), .ld_ready(ld_ready4),
    .ld_addr(ld_addr), .ld_func3(ld_func3), .ld_pd(ld_pd), .ld_rob_tag(ld_rob_tag),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_be(mem_be4), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid4), .wb_pd(wb_pd4), .wb_rob_tag(wb_rob_tag4), .wb_data(wb_data4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    store_wb = 1'b0; st_addr = 32'd0; st_data = 32'd0; st_sh = 1'b0;
    ld_valid = 1'b0; ld_addr = 32'd0; ld_func3 = 3'd0; ld_pd = 7'd0; ld_rob_tag = 5'd0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Load on an idle, empty dut2 with mem_ready=1 and an immediate return.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] rdata, input logic [31:0] exp);
    ld_valid = 1'b1; ld_addr = a; ld_func3 = f3; ld_pd = 7'h22; ld_rob_tag = 5'h11;
    step();
    ld_valid = 1'b0;
    step();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    step();
    mem_rvalid = 1'b0;
    chk({tag, "_valid"}, {31'd0, wb_valid2}, 32'd1);
    chk({tag, "_data"}, wb_data2, exp);
    step();
  endtask

  initial begin
    // Reset state
    do_reset();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", {31'd0, mem_req2}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid2}, 32'd0);
    chk("rst_sq_full", {31'd0, sq_full2}, 32'd0);
    chk("rst_ld_ready", {31'd0, ld_ready2}, 32'd0);
    chk("rst_mem_addr", mem_addr2, 32'd0);
    chk("rst_state", {30'd0, dut2.state_r}, {30'd0, IDLE});
    step();
    reset = 1'b0;

    // Single sw
    do_reset();
    mem_ready = 1'b1;
    store_wb = 1'b1; st_addr = 32'h104; st_data = 32'hDEADBEEF; st_sh = 1'b0;
    step();
    store_wb = 1'b0;
    step();
    chk("sw_req", {30'd0, mem_req2, mem_we2}, 32'd3);
    chk("sw_addr", mem_addr2, 32'h104);
    chk("sw_be", {28'd0, mem_be2}, 32'hF);
    chk("sw_wdata", mem_wdata2, 32'hDEADBEEF);
    step();
    chk("sw_req_drop", {31'd0, mem_req2}, 32'd0);
    chk("sw_empty", {30'd0, dut2.sq_count_s}, 32'd0);

    // Single sh at upper half
    do_reset();
    mem_ready = 1'b1;
    store_wb = 1'b1; st_addr = 32'h102; st_data = 32'h0000ABCD; st_sh = 1'b1;
    step();
    store_wb = 1'b0;
    step();
    chk("sh_addr", mem_addr2, 32'h100);
    chk("sh_be", {28'd0, mem_be2}, 32'hC);
    chk("sh_wdata", mem_wdata2, 32'hABCDABCD);

    // lb with 3 wait cycles
    do_reset();
    mem_ready = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h203; ld_func3 = 3'b000; ld_pd = 7'h15; ld_rob_tag = 5'h0A;
    #1;
    chk("lb_ld_ready", {31'd0, ld_ready2}, 32'd1);
    step();
    ld_valid = 1'b0; ld_addr = 32'h0; ld_pd = 7'h0; ld_rob_tag = 5'h0;
    #1;
    chk("lb_ld_ready_low", {31'd0, ld_ready2}, 32'd0);
    chk("lb_req", {30'd0, mem_req2, mem_we2}, 32'd2);
    chk("lb_addr", mem_addr2, 32'h200);
    step();
    chk("lb_req_drop", {31'd0, mem_req2}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lb_wait_wb", {31'd0, wb_valid2}, 32'd0);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h80FFFF7F;
    step();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    chk("lb_wb_valid", {31'd0, wb_valid2}, 32'd1);
    chk("lb_wb_data", wb_data2, 32'hFFFFFF80);
    chk("lb_wb_pd", {25'd0, wb_pd2}, 32'h15);
    chk("lb_wb_tag", {27'd0, wb_rob_tag2}, 32'h0A);
    step();
    chk("lb_wb_pulse", {31'd0, wb_valid2}, 32'd0);

    // Extension variants
    do_load("lh", 32'h202, 3'b001, 32'h80011234, 32'hFFFF8001);
    do_load("lbu", 32'h201, 3'b100, 32'h0000F200, 32'h000000F2);
    do_load("lhu", 32'h200, 3'b101, 32'h1234ABCD, 32'h0000ABCD);
    do_load("lw", 32'h200, 3'b010, 32'h12345678, 32'h12345678);
    do_load("f3_111", 32'h201, 3'b111, 32'hCAFEF00D, 32'hCAFEF00D);

    // Starvation: three stores queued in dut4, continuous load request
    do_reset();
    st_sh = 1'b0; st_data = 32'h5;
    store_wb = 1'b1; st_addr = 32'h10;
    step();
    st_addr = 32'h20;
    step();
    st_addr = 32'h30;
    step();
    store_wb = 1'b0;
    ld_valid = 1'b1; ld_addr = 32'h400; ld_func3 = 3'b010;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    ngrant = 0;
    for (int cyc = 0; cyc < 60 && ngrant < 4; cyc++) begin
      if (mem_req4 && mem_ready) begin
        grants[ngrant] = mem_we4 ? mem_addr4 : 32'hFFFFFFFF;
        ngrant++;
      end
      step();
    end
    ld_valid = 1'b0; mem_rvalid = 1'b0; mem_ready = 1'b0;
    chk("starve_ngrant", ngrant, 32'd4);
    if (ngrant == 4) begin
      chk("starve_g0", grants[0], 32'h10);
      chk("starve_g1", grants[1], 32'h20);
      chk("starve_g2", grants[2], 32'hFFFFFFFF);
      chk("starve_g3", grants[3], 32'h30);
    end

    // Overflow with SQ_DEPTH=2
    do_reset();
    store_wb = 1'b1; st_addr = 32'h40; st_data = 32'h1;
    step();
    chk("ovf_full_1", {31'd0, sq_full2}, 32'd0);
    st_addr = 32'h44;
    step();
    chk("ovf_full_2", {31'd0, sq_full2}, 32'd1);
    chk("ovf_flag_2", {31'd0, dut2.sq_ovf_r}, 32'd0);
    st_addr = 32'h48;
    step();
    store_wb = 1'b0;
    chk("ovf_flag_3", {31'd0, dut2.sq_ovf_r}, 32'd1);
    chk("ovf_count", {30'd0, dut2.sq_count_s}, 32'd2);
    chk("ovf_head", mem_addr2, 32'h40);

    // Reset during LD_WAIT then stale return
    do_reset();
    mem_ready = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h300; ld_func3 = 3'b010; ld_pd = 7'h3; ld_rob_tag = 5'h4;
    step();
    ld_valid = 1'b0;
    step();
    chk("rw_in_wait", {30'd0, dut2.state_r}, {30'd0, LD_WAIT});
    reset = 1'b1;
    #1;
    chk("rw_state", {30'd0, dut2.state_r}, {30'd0, IDLE});
    step();
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_rvalid = 1'b0;
    chk("rw_no_wb", {31'd0, wb_valid2}, 32'd0);
    chk("rw_wb_data", wb_data2, 32'd0);
    chk("rw_mem_req", {31'd0, mem_req2}, 32'd0);
    chk("rw_idle", {30'd0, dut2.state_r}, {30'd0, IDLE});
    step();
    chk("rw_no_wb_2", {31'd0, wb_valid2}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter SQ_DEPTH, default 2, meaning depth of the retired-store buffer (power of two, 2..4).
REQ-002 Parameter STARVE_MAX, default 2, meaning the number of back-to-back store grants after which a pending load wins.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high; clears all state.
REQ-005 store_wb  in  1  one-cycle pulse from the store queue: a retired store is presented this cycle.
REQ-006 st_addr / st_data  in  32/32  retired store address and data (ps2 value).
REQ-007 st_sh  in  1  1 = sh, 0 = sw.
REQ-008 sq_full  out  1  the store buffer holds SQ_DEPTH entries.
REQ-009 ld_valid  in  1  load request from the mem FU.
REQ-010 ld_ready  out  1  the load is accepted when ld_valid && ld_ready.
REQ-011 ld_addr / ld_func3 / ld_pd / ld_rob_tag  in  32/3/7/5  load address, width code, destination preg and ROB tag.
REQ-012 mem_req / mem_we / mem_addr / mem_wdata / mem_be  out  1/1/32/32/4  single data-memory port.
REQ-013 mem_ready  in  1  the memory accepts mem_req in this cycle.
REQ-014 mem_rvalid / mem_rdata  in  1/32  read return, one per accepted read.
REQ-015 wb_valid / wb_pd / wb_rob_tag / wb_data  out  1/7/5/32  load writeback pulse.

Function
REQ-016 Store pulses SHALL be captured into a FIFO on the same edge; pointers wrap modulo SQ_DEPTH.
REQ-017 A store_wb received while sq_full SHALL be dropped and SHALL set the sticky error flag sq_ovf (internal, bench-visible).
REQ-018 The FSM states SHALL be IDLE, ST_ISSUE, LD_ISSUE and LD_WAIT.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL go to ST_ISSUE, unless ld_valid is asserted and the store streak count equals STARVE_MAX, in which case it SHALL go to LD_ISSUE.
REQ-020 In IDLE with the FIFO empty and ld_valid asserted, the FSM SHALL go to LD_ISSUE.
REQ-021 ld_ready SHALL be 1 only in the IDLE cycle that selects LD_ISSUE; on that edge the load fields are latched.
REQ-022 In ST_ISSUE the block SHALL drive mem_req=1, mem_we=1 and hold the FIFO-head address/data until mem_ready=1.
REQ-023 On the ST_ISSUE handshake the block SHALL pop the FIFO, increment the streak (saturating at STARVE_MAX) and return to IDLE.
REQ-024 For sw, mem_be SHALL be 4'b1111, mem_addr SHALL be st_addr with bits [1:0] cleared, and mem_wdata SHALL be st_data.
REQ-025 For sh, mem_be SHALL be 4'b0011 << (2*st_addr[1]) and mem_wdata SHALL be {2{st_data[15:0]}}.
REQ-026 In LD_ISSUE the block SHALL drive mem_req=1, mem_we=0 and the word-aligned address, and SHALL move to LD_WAIT on mem_ready.
REQ-027 The streak SHALL be cleared on every load grant.
REQ-028 In LD_WAIT on mem_rvalid, the block SHALL pulse wb_valid for exactly one cycle (registered, the cycle after mem_rvalid) and return to IDLE.
REQ-029 wb_data SHALL be selected by ld_addr[1:0] and extended per func3: 000 lb sign, 001 lh sign, 010 lw, 100 lbu zero, 101 lhu zero.
REQ-030 Other func3 values SHALL be treated as lw.
REQ-031 Stores SHALL keep entering the FIFO during every state.
REQ-032 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-033 When the FIFO is empty, mem_req SHALL be 0 in IDLE.
REQ-034 mem_rvalid outside LD_WAIT SHALL be ignored.

Reset
REQ-035 Reset SHALL set the FSM to IDLE and clear the FIFO pointers, count, streak and sq_ovf.
REQ-036 Reset SHALL drive all outputs to 0 (sq_full=0, ld_ready=0, mem_*=0, wb_*=0).
REQ-037 Reset asserted mid-transaction SHALL abandon it without writeback; a later stale mem_rvalid SHALL be ignored per REQ-034.

Structure
REQ-038 The types_pkg package SHALL hold mem_arb_state_t (enum), st_req_t (addr, data, sh) and ld_req_t (addr, func3, pd, rob_tag).
REQ-039 The FIFO SHALL be the sub-module st_fifo (push, pop, head, count, full, empty).
REQ-040 The load extender SHALL be a combinational function inside mem_port_arb.

Verification
REQ-041 Single sw: store_wb with addr 0x104, data 0xDEADBEEF, mem_ready=1 -> mem_req/we next cycle, mem_addr 0x104, be 1111, FIFO empty after.
REQ-042 sh at addr 0x102, data 0x0000ABCD -> mem_be 1100, mem_wdata 0xABCDABCD.
REQ-043 lb at 0x203, func3 000, mem_rdata 0x80FF_FF7F returned after 3 wait cycles -> wb_data 0xFFFFFF80, wb_pd and tag echoed, one-cycle wb_valid.
REQ-044 3 stores queued (SQ_DEPTH=4) plus a continuous ld_valid -> grant order: store, store, load, store.
REQ-045 Three store_wb pulses with mem_ready=0 and SQ_DEPTH=2 -> sq_full=1 after two, third dropped, sq_ovf=1.
REQ-046 Reset during LD_WAIT, then mem_rvalid -> no wb_valid, FSM IDLE, all outputs 0.
